// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster scan state encoding and screen geometry
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

endpackage

// File: rtl/raster_scan_gen_if.sv
// rtl/raster_scan_gen_if.sv - request/pixel bundle between a scan requester and the raster generator
interface raster_scan_gen_if #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15
);

  logic              start;
  logic              abort;
  logic [X_W-1:0]    xStart;
  logic [Y_W-1:0]    yStart;
  logic [X_W-1:0]    width;
  logic [Y_W-1:0]    height;
  logic              plotReady;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] addr;
  logic              plot;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, xStart, yStart, width, height, plotReady,
    input  x, y, addr, plot, busy, done
  );

  modport slave (
    input  start, abort, xStart, yStart, width, height, plotReady,
    output x, y, addr, plot, busy, done
  );

endinterface

// File: rtl/axis_counter.sv
// rtl/axis_counter.sv - loadable, enabled up-counter with terminal-count flag
module axis_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] value,
  output logic         tc
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign tc    = (value_q == last_val);

endmodule

// File: rtl/raster_scan_gen.sv
// rtl/raster_scan_gen.sv - walks a screen-clipped rectangle row by row, one pixel per plot handshake
module raster_scan_gen
  import vga_pkg::*;
#(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int SCR_W  = SCR_W_DEF,
  parameter int SCR_H  = SCR_H_DEF,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [X_W-1:0]    xStart,
  input  logic [Y_W-1:0]    yStart,
  input  logic [X_W-1:0]    width,
  input  logic [Y_W-1:0]    height,
  input  logic              plotReady,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam logic [X_W:0] SCR_W_V = (X_W+1)'(SCR_W);
  localparam logic [Y_W:0] SCR_H_V = (Y_W+1)'(SCR_H);

  scan_state_e       state_q, state_d;
  logic [X_W-1:0]    xs_q, xs_d;
  logic [X_W-1:0]    xl_q, xl_d;
  logic [Y_W-1:0]    yl_q, yl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic           x_load, x_en, x_tc;
  logic           y_load, y_en, y_tc;
  logic [X_W-1:0] x_load_val;

  // One extra bit so the clip arithmetic against the screen edge cannot wrap.
  logic [X_W:0] rem_w, eff_w, x_last;
  logic [Y_W:0] rem_h, eff_h, y_last;
  logic         x_oob, y_oob, rect_ok, hs;

  always_comb begin
    x_oob   = ({1'b0, xStart} >= SCR_W_V);
    y_oob   = ({1'b0, yStart} >= SCR_H_V);
    rem_w   = SCR_W_V - {1'b0, xStart};
    rem_h   = SCR_H_V - {1'b0, yStart};
    eff_w   = ({1'b0, width}  < rem_w) ? {1'b0, width}  : rem_w;
    eff_h   = ({1'b0, height} < rem_h) ? {1'b0, height} : rem_h;
    x_last  = {1'b0, xStart} + eff_w - (X_W+1)'(1);
    y_last  = {1'b0, yStart} + eff_h - (Y_W+1)'(1);
    rect_ok = !x_oob && !y_oob && (eff_w != '0) && (eff_h != '0);
    hs      = plot && plotReady;
  end

  always_comb begin
    state_d    = state_q;
    xs_d       = xs_q;
    xl_d       = xl_q;
    yl_d       = yl_q;
    addr_d     = addr_q;
    x_load     = 1'b0;
    x_en       = 1'b0;
    y_load     = 1'b0;
    y_en       = 1'b0;
    x_load_val = (state_q == ST_IDLE) ? xStart : xs_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          xs_d    = xStart;
          xl_d    = x_last[X_W-1:0];
          yl_d    = y_last[Y_W-1:0];
          addr_d  = '0;
          x_load  = 1'b1;
          y_load  = 1'b1;
          state_d = rect_ok ? ST_SCAN : ST_DONE;
        end
      end
      ST_SCAN: begin
        // Abort wins over a handshake in the same cycle: the pixel is not consumed.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hs) begin
          if (x_tc && y_tc) begin
            state_d = ST_DONE;
          end else if (x_tc) begin
            x_load = 1'b1;
            y_en   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            x_en   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      xl_q    <= '0;
      yl_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      xl_q    <= xl_d;
      yl_q    <= yl_d;
      addr_q  <= addr_d;
    end
  end

  axis_counter #(.W(X_W)) u_x_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (x_load),
    .load_val (x_load_val),
    .en       (x_en),
    .last_val (xl_q),
    .value    (x),
    .tc       (x_tc)
  );

  axis_counter #(.W(Y_W)) u_y_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (y_load),
    .load_val (yStart),
    .en       (y_en),
    .last_val (yl_q),
    .value    (y),
    .tc       (y_tc)
  );

  assign addr = addr_q;
  assign plot = (state_q == ST_SCAN);
  assign busy = (state_q == ST_SCAN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_raster_scan_gen.sv
// tb/tb_raster_scan_gen.sv - directed table-driven bench for raster_scan_gen
module tb_raster_scan_gen;

  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int ADDR_W = 15;

  typedef struct {
    int xs, ys, w, h;
    int ew;
    int exp_n;
    int lx, ly;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  raster_scan_gen_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) bus ();

  raster_scan_gen #(
    .X_W(X_W), .Y_W(Y_W), .SCR_W(160), .SCR_H(120), .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .abort     (bus.abort),
    .xStart    (bus.xStart),
    .yStart    (bus.yStart),
    .width     (bus.width),
    .height    (bus.height),
    .plotReady (bus.plotReady),
    .x         (bus.x),
    .y         (bus.y),
    .addr      (bus.addr),
    .plot      (bus.plot),
    .busy      (bus.busy),
    .done      (bus.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic start_scan(input int xs, input int ys, input int w, input int h);
    @(negedge clk);
    bus.xStart = X_W'(xs);
    bus.yStart = Y_W'(ys);
    bus.width  = X_W'(w);
    bus.height = Y_W'(h);
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_scan(input vec_t v, input string nm);
    int n, dcnt, bad, cyc, first_cyc, lx, ly, la, ex, ey;
    n = 0; dcnt = 0; bad = 0; cyc = 0; first_cyc = -1; lx = -1; ly = -1; la = -1;
    bus.plotReady = 1'b1;
    start_scan(v.xs, v.ys, v.w, v.h);
    while (cyc < 64 && dcnt == 0) begin
      if (bus.plot) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (v.ew == 0) begin
          bad++;
        end else begin
          ex = v.xs + n % v.ew;
          ey = v.ys + n / v.ew;
          if (bus.x !== X_W'(ex) || bus.y !== Y_W'(ey) || bus.addr !== ADDR_W'(n) || bus.busy !== 1'b1)
            bad++;
        end
        lx = int'(bus.x); ly = int'(bus.y); la = int'(bus.addr);
        n++;
      end
      if (bus.done) begin
        dcnt++;
        if (bus.plot || bus.busy) bad++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, ".pixels"}, n, v.exp_n);
    chk({nm, ".done_seen"}, dcnt, 1);
    chk({nm, ".seq_errs"}, bad, 0);
    chk({nm, ".done_1cyc"}, int'(bus.done), 0);
    if (v.exp_n > 0) begin
      chk({nm, ".latency"}, first_cyc, 0);
      chk({nm, ".last_x"}, lx, v.lx);
      chk({nm, ".last_y"}, ly, v.ly);
      chk({nm, ".last_addr"}, la, v.exp_n - 1);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int hs, bad, cyc, dseen;
    bit rdy;

    vecs[0] = '{xs: 10,  ys: 5,   w: 3, h: 2, ew: 3, exp_n: 6, lx: 12,  ly: 6};
    vecs[1] = '{xs: 158, ys: 0,   w: 5, h: 1, ew: 2, exp_n: 2, lx: 159, ly: 0};
    vecs[2] = '{xs: 0,   ys: 118, w: 2, h: 5, ew: 2, exp_n: 4, lx: 1,   ly: 119};
    vecs[3] = '{xs: 10,  ys: 5,   w: 0, h: 2, ew: 0, exp_n: 0, lx: 0,   ly: 0};
    vecs[4] = '{xs: 160, ys: 0,   w: 3, h: 3, ew: 0, exp_n: 0, lx: 0,   ly: 0};
    vecs[5] = '{xs: 0,   ys: 120, w: 3, h: 3, ew: 0, exp_n: 0, lx: 0,   ly: 0};
    vecs[6] = '{xs: 159, ys: 119, w: 4, h: 4, ew: 1, exp_n: 1, lx: 159, ly: 119};
    vecs[7] = '{xs: 5,   ys: 10,  w: 1, h: 3, ew: 1, exp_n: 3, lx: 5,   ly: 12};

    checks = 0; errors = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.plotReady = 1'b1;
    bus.xStart = '0; bus.yStart = '0; bus.width = '0; bus.height = '0;
    reset = 1'b1;
    #1;
    chk("reset.outputs", int'({bus.plot, bus.busy, bus.done}), 0);
    chk("reset.xya", int'(bus.x) + int'(bus.y) + int'(bus.addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_scan(vecs[i], $sformatf("vec%0d", i));
    end

    // Stall on the second pixel of a 2x2 scan
    hs = 0; bad = 0; cyc = 0; dseen = 0;
    bus.plotReady = 1'b1;
    start_scan(20, 30, 2, 2);
    while (cyc < 20 && dseen == 0) begin
      rdy = !(cyc >= 1 && cyc <= 3);
      bus.plotReady = rdy;
      if (bus.plot) begin
        if (bus.x !== X_W'(20 + hs % 2) || bus.y !== Y_W'(30 + hs / 2) || bus.addr !== ADDR_W'(hs))
          bad++;
        if (rdy) hs++;
      end
      if (bus.done) dseen = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.plotReady = 1'b1;
    chk("stall.handshakes", hs, 4);
    chk("stall.hold_errs", bad, 0);
    chk("stall.done", dseen, 1);

    // Abort on the third pixel of a 4x4 scan; a mid-scan start is ignored
    start_scan(0, 0, 4, 4);
    @(posedge clk); #1;
    bus.xStart = X_W'(50); bus.yStart = Y_W'(50); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("abort.ignored_start_x", int'(bus.x), 2);
    chk("abort.ignored_start_y", int'(bus.y), 0);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort.busy", int'(bus.busy), 0);
    chk("abort.plot", int'(bus.plot), 0);
    chk("abort.done", int'(bus.done), 0);
    dseen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done || bus.plot) dseen++;
    end
    chk("abort.quiet", dseen, 0);
    chk("abort.x_held", int'(bus.x), 2);
    chk("abort.addr_held", int'(bus.addr), 2);
    run_scan('{xs: 7, ys: 8, w: 1, h: 1, ew: 1, exp_n: 1, lx: 7, ly: 8}, "after_abort");

    // Asynchronous reset mid-scan
    start_scan(30, 40, 4, 4);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst.plot_busy_done", int'({bus.plot, bus.busy, bus.done}), 0);
    chk("rst.x", int'(bus.x), 0);
    chk("rst.y", int'(bus.y), 0);
    chk("rst.addr", int'(bus.addr), 0);
    @(negedge clk);
    reset = 1'b0;
    dseen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done || bus.plot) dseen++;
    end
    chk("rst.discarded", dseen, 0);
    run_scan('{xs: 100, ys: 50, w: 2, h: 2, ew: 2, exp_n: 4, lx: 101, ly: 51}, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
